twiddle64_rotate: RTL and testbench

TWIDDLE64_ROTATE -- requirements
Module: twiddle64_rotate

---
 rtl/twiddle64_pkg.sv | 37 +++
 rtl/twiddle64_rot_quad.sv | 64 ++++++
 rtl/twiddle64_rotate.sv | 130 +++++++++++++
 tb/tb_twiddle64_rotate.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/twiddle64_pkg.sv
// Shared constants, quadrant encoding and twiddle index mapping for the 64-point rotator.
// Counter-to-twiddle mapping: k = s[5:3] * s[2:0], folded into an index 0..8 plus quadrant.
package twiddle64_pkg;

  localparam int FFT64_N  = 64;
  localparam int TW_SEL_W = 4;

  typedef enum logic [1:0] {
    QUAD_0   = 2'd0,
    QUAD_90  = 2'd1,
    QUAD_180 = 2'd2,
    QUAD_270 = 2'd3
  } quad_e;

  typedef struct packed {
    logic [TW_SEL_W-1:0] tw_sel;
    logic                swap;
    quad_e               q;
  } tw_map_t;

  function automatic tw_map_t tw_map(input logic [5:0] s);
    logic [5:0] k;
    tw_map_t    m;
    k   = {3'b000, s[5:3]} * {3'b000, s[2:0]};
    m.q = quad_e'(k[5:4]);
    if (k[3:0] <= 4'd8) begin
      m.tw_sel = k[3:0];
      m.swap   = 1'b0;
    end else begin
      // 16 - r modulo 16 is simply the 4-bit negation of r
      m.tw_sel = 4'd0 - k[3:0];
      m.swap   = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/twiddle64_rot_quad.sv
// Combinational swap-sum of the twiddle partial products followed by a quadrant rotation.
module twiddle64_rot_quad
  import twiddle64_pkg::*;
#(
  parameter int DATA_WIDTH = 14
) (
  input  logic signed [DATA_WIDTH:0]   p_rere,
  input  logic signed [DATA_WIDTH:0]   p_imim,
  input  logic signed [DATA_WIDTH:0]   p_reim,
  input  logic signed [DATA_WIDTH:0]   p_imre,
  input  logic                         swap,
  input  quad_e                        q,
  output logic signed [DATA_WIDTH+1:0] rot_re,
  output logic signed [DATA_WIDTH+1:0] rot_im
);

  localparam int SW = DATA_WIDTH + 2;

  logic signed [SW-1:0] rere_x_s, imim_x_s, reim_x_s, imre_x_s;
  logic signed [SW-1:0] a_s, b_s;

  assign rere_x_s = {p_rere[DATA_WIDTH], p_rere};
  assign imim_x_s = {p_imim[DATA_WIDTH], p_imim};
  assign reim_x_s = {p_reim[DATA_WIDTH], p_reim};
  assign imre_x_s = {p_imre[DATA_WIDTH], p_imre};

  // Base sum selection (swap mirrors the twiddle around 45 degrees) and quadrant rotation
  always_comb begin
    a_s    = {SW{1'b0}};
    b_s    = {SW{1'b0}};
    rot_re = {SW{1'b0}};
    rot_im = {SW{1'b0}};
    if (swap) begin
      a_s = reim_x_s + imre_x_s;
      b_s = imim_x_s - rere_x_s;
    end else begin
      a_s = rere_x_s + imim_x_s;
      b_s = imre_x_s - reim_x_s;
    end
    case (q)
      QUAD_0: begin
        rot_re = a_s;
        rot_im = b_s;
      end
      QUAD_90: begin
        rot_re = b_s;
        rot_im = -a_s;
      end
      QUAD_180: begin
        rot_re = -a_s;
        rot_im = -b_s;
      end
      QUAD_270: begin
        rot_re = -b_s;
        rot_im = a_s;
      end
      default: begin
        rot_re = a_s;
        rot_im = b_s;
      end
    endcase
  end

endmodule

// File: rtl/twiddle64_rotate.sv
// Two-stage 64-point twiddle rotator: index generation, swap-sum, quadrant rotation, halving.
// Optional TWIDDLE64_ROTATE_ROUND_EN selects round-half-up halving instead of truncation.
module twiddle64_rotate
  import twiddle64_pkg::*;
#(
  parameter int DATA_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [TW_SEL_W-1:0]        tw_sel,
  input  logic signed [DATA_WIDTH:0] p_rere,
  input  logic signed [DATA_WIDTH:0] p_imim,
  input  logic signed [DATA_WIDTH:0] p_reim,
  input  logic signed [DATA_WIDTH:0] p_imre,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_WIDTH:0] out_real,
  output logic signed [DATA_WIDTH:0] out_imag,
  output logic                       out_first,
  output logic                       out_last
);

  localparam int SW = DATA_WIDTH + 2;

  // Halve a rotated sum back to the sample width; widened first so the rounding add cannot wrap.
  function automatic logic signed [DATA_WIDTH:0] reduce(input logic signed [SW-1:0] x);
    logic signed [SW:0] ext;
    ext = x;
`ifdef TWIDDLE64_ROTATE_ROUND_EN
    return (DATA_WIDTH+1)'((ext + $signed({{SW{1'b0}}, 1'b1})) >>> 1);
`else
    return (DATA_WIDTH+1)'(ext >>> 1);
`endif
  endfunction

  logic [5:0]                s_r;
  logic                      en_s;
  logic                      acc_s;
  tw_map_t                   map_s;

  logic                      v1_r;
  logic signed [DATA_WIDTH:0] rere_r, imim_r, reim_r, imre_r;
  quad_e                     q_r;
  logic                      swap_r;
  logic                      first1_r;
  logic                      last1_r;

  logic signed [SW-1:0]      rot_re_s, rot_im_s;
  logic signed [DATA_WIDTH:0] red_re_s, red_im_s;

  assign en_s     = !out_valid | out_ready;
  assign acc_s    = in_valid & en_s;
  assign in_ready = en_s;
  assign map_s    = tw_map(s_r);
  assign tw_sel   = map_s.tw_sel;

  // Sample counter within the 64-point frame, advancing only on accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r <= 6'd0;
    end else if (acc_s) begin
      s_r <= s_r + 6'd1;
    end
  end

  // Stage 1: capture partial products and the rotation controls for this sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r     <= 1'b0;
      rere_r   <= '0;
      imim_r   <= '0;
      reim_r   <= '0;
      imre_r   <= '0;
      q_r      <= QUAD_0;
      swap_r   <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
    end else if (en_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        rere_r   <= p_rere;
        imim_r   <= p_imim;
        reim_r   <= p_reim;
        imre_r   <= p_imre;
        q_r      <= map_s.q;
        swap_r   <= map_s.swap;
        first1_r <= (s_r == 6'd0);
        last1_r  <= (s_r == 6'd63);
      end
    end
  end

  twiddle64_rot_quad #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rot_quad (
    .p_rere (rere_r),
    .p_imim (imim_r),
    .p_reim (reim_r),
    .p_imre (imre_r),
    .swap   (swap_r),
    .q      (q_r),
    .rot_re (rot_re_s),
    .rot_im (rot_im_s)
  );

  assign red_re_s = reduce(rot_re_s);
  assign red_im_s = reduce(rot_im_s);

  // Stage 2: registered output sample; held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (en_s) begin
      out_valid <= v1_r;
      if (v1_r) begin
        out_real  <= red_re_s;
        out_imag  <= red_im_s;
        out_first <= first1_r;
        out_last  <= last1_r;
      end
    end
  end

endmodule

// File: tb/tb_twiddle64_rotate.sv
// Scoreboard bench for twiddle64_rotate: expectations queued at accept, checked by a monitor.
module tb_twiddle64_rotate;

  localparam int DW = 14;
`ifdef TWIDDLE64_ROTATE_ROUND_EN
  localparam int ODD_EXP = 2;
`else
  localparam int ODD_EXP = 1;
`endif

  typedef struct {
    int re;
    int im;
    int first;
    int last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        tw_sel;
  logic signed [DW:0] p_rere, p_imim, p_reim, p_imre;
  logic              out_valid;
  logic              out_ready;
  logic signed [DW:0] out_real, out_imag;
  logic              out_first, out_last;

  int   tests = 0;
  int   fails = 0;
  int   s_m   = 0;
  exp_t sb[$];

  twiddle64_rotate #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tw_sel(tw_sel),
    .p_rere(p_rere), .p_imim(p_imim), .p_reim(p_reim), .p_imre(p_imre),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int tw_exp(input int s);
    int k, r;
    k = (s / 8) * (s % 8);
    r = k % 16;
    return (r > 8) ? 16 - r : r;
  endfunction

  function automatic exp_t model(input int s, input int rr, input int ii, input int ri, input int ir);
    int k, r, q, a, b, x, y;
    exp_t e;
    k = (s / 8) * (s % 8);
    q = k / 16;
    r = k % 16;
    if (r > 8) begin a = ri + ir; b = ii - rr; end
    else       begin a = rr + ii; b = ir - ri; end
    case (q)
      0:       begin x = a;  y = b;  end
      1:       begin x = b;  y = -a; end
      2:       begin x = -a; y = -b; end
      default: begin x = -b; y = a;  end
    endcase
`ifdef TWIDDLE64_ROTATE_ROUND_EN
    e.re = (x + 1) >>> 1;
    e.im = (y + 1) >>> 1;
`else
    e.re = x >>> 1;
    e.im = y >>> 1;
`endif
    e.first = (s == 0) ? 1 : 0;
    e.last  = (s == 63) ? 1 : 0;
    return e;
  endfunction

  task automatic send(input int rr, input int ii, input int ri, input int ir,
                      input bit hand, input int hre, input int him, output int tw_obs);
    exp_t e;
    bit   done;
    bit   rdy;
    done     = 1'b0;
    tw_obs   = -1;
    in_valid = 1'b1;
    p_rere   = rr[DW:0];
    p_imim   = ii[DW:0];
    p_reim   = ri[DW:0];
    p_imre   = ir[DW:0];
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      tw_obs = int'(tw_sel);
      rdy    = in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    #1;
    if (!done) begin
      chk("send_timeout", 0, 1);
    end else begin
      chk("tw_sel", tw_obs, tw_exp(s_m));
      e = model(s_m, rr, ii, ri, ir);
      if (hand) begin
        e.re = hre;
        e.im = him;
      end
      sb.push_back(e);
      s_m = (s_m + 1) % 64;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare every handshaken output against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_real", int'(out_real), e.re);
        chk("out_imag", int'(out_imag), e.im);
        chk("out_first", int'(out_first), e.first);
        chk("out_last", int'(out_last), e.last);
      end
    end
  end

  initial begin
    int tw;
    int snap_re, snap_im, snap_f, snap_l;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    p_rere = '0; p_imim = '0; p_reim = '0; p_imre = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_real", int'(out_real), 0);
    chk("rst_out_imag", int'(out_imag), 0);
    chk("rst_out_first", int'(out_first), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_tw_sel", int'(tw_sel), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Full frame sweep covering every quadrant and both swap modes
    for (int i = 0; i < 64; i++) begin
      send((i * 97) % 2000 - 1000, (i * 53) % 1500 - 700, (i * 31) % 900 - 450,
           (i * 71) % 1800 - 900, 1'b0, 0, 0, tw);
      if (i == 0)  chk("tw_s0", tw, 0);
      if (i == 9)  chk("tw_s9", tw, 1);
      if (i == 63) chk("tw_s63", tw, 1);
    end

    // Wrapped frame: odd sum at s=0, then q=2 case at s=54 (k=36)
    send(3, 0, 0, 0, 1'b1, ODD_EXP, 0, tw);
    chk("tw_odd_s0", tw, 0);
    for (int i = 1; i < 54; i++)
      send(i * 11 - 300, 200 - i * 7, i * 5, -i * 3, 1'b0, 0, 0, tw);
    send(1000, 0, 0, 0, 1'b1, -500, 0, tw);
    chk("tw_s54", tw, 4);

    // Backpressure with a full pipe
    send(1234, -321, 77, -88, 1'b0, 0, 0, tw);
    send(-2222, 1111, -55, 66, 1'b0, 0, 0, tw);
    out_ready = 1'b0;
    snap_re = int'(out_real); snap_im = int'(out_imag);
    snap_f  = int'(out_first); snap_l = int'(out_last);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_real_stable", int'(out_real), snap_re);
      chk("bp_imag_stable", int'(out_imag), snap_im);
      chk("bp_flags_stable", int'({out_first, out_last}), (snap_f << 1) | snap_l);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;

    // Run into the next frame and reset mid-frame at s=30
    while (s_m != 30)
      send(s_m * 13 - 400, 300 - s_m * 9, s_m * 21 - 100, 50 - s_m * 4, 1'b0, 0, 0, tw);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_tw_sel", int'(tw_sel), 0);
    sb.delete();
    s_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(500, 100, -20, 40, 1'b0, 0, 0, tw);
    chk("tw_after_midrst", tw, 0);
    @(negedge clk);
    chk("lat_stage1", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_stage2", int'(out_valid), 1);
    chk("first_after_midrst", int'(out_first), 1);

    repeat (10) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
